// File: rtl/axis_ram_fifo_ctrl_if.sv
// AXI4-Stream handshake bundle shared by the ingress and egress sides of the FIFO controller.
interface axis_ram_fifo_ctrl_if #(
    parameter int unsigned DWIDTH = 32
);
    logic [DWIDTH-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_ram_fifo_ctrl.sv
// AXI4-Stream FIFO controller driving an external dual-port RAM with 1-cycle registered read.
// Port A writes ingress beats, port B reads them back into a 2-entry skid stage that presents
// first-word-fall-through data on the egress stream.
module axis_ram_fifo_ctrl #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    axis_ram_fifo_ctrl_if.slave   s_axis,
    axis_ram_fifo_ctrl_if.master  m_axis,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [AWIDTH-1:0]     ram_addra,
    output logic [DWIDTH:0]       ram_dia,
    output logic                  ram_enb,
    output logic                  ram_web,
    output logic [AWIDTH-1:0]     ram_addrb,
    input  logic [DWIDTH:0]       ram_dob,
    output logic [AWIDTH+1:0]     occupancy
);

    localparam int unsigned DepthInt = 1 << AWIDTH;
    localparam logic [AWIDTH:0] RamFull = DepthInt[AWIDTH:0];

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   ram_count_q, ram_count_d;
    logic              inflight_q, inflight_d;
    logic [DWIDTH:0]   skid_q [2];
    logic [DWIDTH:0]   skid_d [2];
    logic [1:0]        skid_count_q, skid_count_d;
    logic              s_ready_q, s_ready_d;
    logic [AWIDTH+1:0] occupancy_q, occupancy_d;

    logic              wr_hs;
    logic              pop;
    logic              issue;
    logic [1:0]        skid_left;

    // Outputs are forced idle while reset is asserted so nothing leaks from stale state.
    assign s_axis.tready = s_ready_q && !reset;
    assign m_axis.tvalid = (skid_count_q != 2'd0) && !reset;
    assign m_axis.tdata  = skid_q[0][DWIDTH-1:0];
    assign m_axis.tlast  = skid_q[0][DWIDTH];

    assign ram_ena   = wr_hs;
    assign ram_wea   = wr_hs;
    assign ram_addra = wr_ptr_q;
    assign ram_dia   = {s_axis.tlast, s_axis.tdata};
    assign ram_enb   = issue;
    assign ram_web   = 1'b0;
    assign ram_addrb = rd_ptr_q;
    assign occupancy = reset ? '0 : occupancy_q;

    // Next-state: handshakes, read issue, skid shift/capture and counters.
    always_comb begin
        wr_hs     = s_axis.tvalid && s_axis.tready;
        pop       = m_axis.tvalid && m_axis.tready;
        skid_left = skid_count_q - {1'b0, pop};
        // Issue only if the returning word is guaranteed a free skid slot.
        issue     = !reset && (ram_count_q != '0) &&
                    ((skid_left + {1'b0, inflight_q}) < 2'd2);

        skid_d       = skid_q;
        skid_count_d = skid_left;
        if (pop) begin
            skid_d[0] = skid_q[1];
        end
        if (inflight_q) begin
            skid_d[skid_left[0]] = ram_dob;
            skid_count_d         = skid_left + 2'd1;
        end

        inflight_d  = issue;
        wr_ptr_d    = wr_ptr_q + AWIDTH'(wr_hs);
        rd_ptr_d    = rd_ptr_q + AWIDTH'(issue);
        ram_count_d = ram_count_q + (AWIDTH+1)'(wr_hs) - (AWIDTH+1)'(issue);
        s_ready_d   = (ram_count_d != RamFull);
        occupancy_d = {1'b0, ram_count_d} + (AWIDTH+2)'(issue) + (AWIDTH+2)'(skid_count_d);
    end

    // State register with synchronous reset; ready comes up as soon as reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_count_q  <= '0;
            inflight_q   <= 1'b0;
            skid_count_q <= 2'd0;
            s_ready_q    <= 1'b1;
            occupancy_q  <= '0;
            skid_q[0]    <= '0;
            skid_q[1]    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_count_q  <= ram_count_d;
            inflight_q   <= inflight_d;
            skid_count_q <= skid_count_d;
            s_ready_q    <= s_ready_d;
            occupancy_q  <= occupancy_d;
            skid_q[0]    <= skid_d[0];
            skid_q[1]    <= skid_d[1];
        end
    end

endmodule

// File: tb/tb_axis_ram_fifo_ctrl.sv
// Bench for axis_ram_fifo_ctrl: behavioural RAM, queue scoreboard and occupancy model.
module tb_axis_ram_fifo_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 9;

    logic          clk;
    logic          reset;
    logic          ram_ena, ram_wea, ram_enb, ram_web;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW:0]   ram_dia, ram_dob;
    logic [AW+1:0] occupancy;

    axis_ram_fifo_ctrl_if #(.DWIDTH(DW)) s_if ();
    axis_ram_fifo_ctrl_if #(.DWIDTH(DW)) m_if ();

    axis_ram_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dia   (ram_dia),
        .ram_enb   (ram_enb),
        .ram_web   (ram_web),
        .ram_addrb (ram_addrb),
        .ram_dob   (ram_dob),
        .occupancy (occupancy)
    );

    // External dual-port RAM with registered read.
    logic [DW:0] mem [1 << AW];
    always @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= mem[ram_addrb];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          src_pending = 0;
    int          src_remaining = 0;
    logic [31:0] src_data = '0;
    bit          src_last_one = 0;
    int          wr_phase, rd_phase;
    int          first_wr_cyc, first_val_cyc, first_enb_cyc, first_rdy_cyc;
    bit          arm_rise = 0;
    bit          chk_sready = 0;
    bit          chk_nobubble = 0;
    int          phase_n = 0;
    logic [DW:0] exp_q [$];
    int          model_occ = 0;
    bit          prev_stall = 0;
    logic [DW:0] prev_word;
    bit          last_enb;
    int          last_occ;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_phase();
        wr_phase = 0;
        rd_phase = 0;
        first_wr_cyc = -1;
        first_val_cyc = -1;
        first_enb_cyc = -1;
        first_rdy_cyc = -1;
    endtask

    // One clock cycle: drive at negedge, check and account handshakes, then wait the edge.
    task automatic tick(input bit v_en, input bit r_en);
        bit          s_hs, m_hs;
        logic [DW:0] got;
        @(negedge clk);
        cyc++;
        if (!src_pending && v_en && src_remaining > 0) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = src_data;
            s_if.tlast  = src_last_one ? 1'b1 : 1'($urandom_range(0, 1));
            src_pending = 1;
        end else if (!src_pending) begin
            s_if.tvalid = 1'b0;
        end
        m_if.tready = r_en;
        #1;
        last_occ = int'(occupancy);
        last_enb = ram_enb;
        check("occupancy", 64'(occupancy), 64'(model_occ));
        check("occupancy_max", 64'(occupancy <= 11'd514), 64'd1);
        if (prev_stall) begin
            check("stall_valid", 64'(m_if.tvalid), 64'd1);
            check("stall_word", 64'({m_if.tlast, m_if.tdata}), 64'(prev_word));
        end
        if (chk_sready) check("sready_high", 64'(s_if.tready), 64'd1);
        if (chk_nobubble && first_val_cyc >= 0 && rd_phase < phase_n)
            check("no_bubble", 64'(m_if.tvalid), 64'd1);
        if (arm_rise) begin
            if (ram_enb && first_enb_cyc < 0) first_enb_cyc = cyc;
            if (s_if.tready && first_rdy_cyc < 0) first_rdy_cyc = cyc;
        end
        s_hs = s_if.tvalid && s_if.tready;
        m_hs = m_if.tvalid && m_if.tready;
        if (s_hs && first_wr_cyc < 0) first_wr_cyc = cyc;
        if (m_if.tvalid && first_val_cyc < 0) first_val_cyc = cyc;
        if (s_hs) begin
            exp_q.push_back({s_if.tlast, s_if.tdata});
            src_pending = 0;
            src_data++;
            if (src_remaining > 0) src_remaining--;
            wr_phase++;
            model_occ++;
        end
        if (m_hs) begin
            check("pop_has_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                got = {m_if.tlast, m_if.tdata};
                check("pop_word", 64'(got), 64'(exp_q.pop_front()));
            end
            rd_phase++;
            model_occ--;
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_word  = {m_if.tlast, m_if.tdata};
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        src_pending = 0;
        src_remaining = 0;
        #1;
        check("rst_sready", 64'(s_if.tready), 64'd0);
        check("rst_mvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_ram_en", 64'({ram_ena, ram_wea, ram_enb}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_occ = 0;
        prev_stall = 0;
        #1;
        check("post_rst_sready", 64'(s_if.tready), 64'd1);
        check("post_rst_mvalid", 64'(m_if.tvalid), 64'd0);
        check("post_rst_occ", 64'(occupancy), 64'd0);
        check("post_rst_ram_en", 64'({ram_ena, ram_wea, ram_enb}), 64'd0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || src_pending); i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_occ", 64'(last_occ), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tlast = 1'b0;
        m_if.tready = 1'b0;
        do_reset();

        // Single beat latency.
        begin_phase();
        src_data = 32'hA5A5A5A5;
        src_last_one = 1;
        src_remaining = 1;
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
        check("single_latency", 64'(first_val_cyc - first_wr_cyc), 64'd3);
        check("single_count", 64'(rd_phase), 64'd1);
        check("single_occ", 64'(last_occ), 64'd0);
        src_last_one = 0;

        // Continuous stream, both sides ready.
        begin_phase();
        src_data = 32'd0;
        src_remaining = 1000;
        phase_n = 1000;
        chk_sready = 1;
        chk_nobubble = 1;
        for (int i = 0; i < 1100 && rd_phase < 1000; i++) tick(1'b1, 1'b1);
        chk_sready = 0;
        chk_nobubble = 0;
        check("stream_count", 64'(rd_phase), 64'd1000);
        drain(20);

        // Fill until full with the consumer stalled, then release.
        begin_phase();
        src_remaining = 600;
        for (int i = 0; i < 600; i++) tick(1'b1, 1'b0);
        check("fill_accepted", 64'(wr_phase), 64'd514);
        check("fill_occ", 64'(last_occ), 64'd514);
        src_remaining = 0;
        arm_rise = 1;
        drain(700);
        arm_rise = 0;
        check("full_ready_rise", 64'(first_rdy_cyc - first_enb_cyc), 64'd1);
        check("fill_drained", 64'(rd_phase), 64'd515);

        // Random valid/ready with random tlast.
        begin_phase();
        src_remaining = 5000;
        for (int i = 0; i < 40000 && rd_phase < 5000; i++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("random_count", 64'(rd_phase), 64'd5000);
        drain(20);

        // Reset with words buffered and a read in flight.
        begin_phase();
        src_remaining = 300;
        for (int i = 0; i < 400 && wr_phase < 300; i++) tick(1'b1, 1'b0);
        check("pre_rst_written", 64'(wr_phase), 64'd300);
        tick(1'b0, 1'b1);
        check("pre_rst_inflight", 64'(last_enb), 64'd1);
        do_reset();
        begin_phase();
        src_data = 32'h1;
        src_remaining = 1;
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1);
        check("post_rst_beats", 64'(rd_phase), 64'd1);
        check("post_rst_empty", 64'(exp_q.size()), 64'd0);

        // Pointer wrap with periodic consumer stalls.
        begin_phase();
        src_data = 32'h1000;
        src_remaining = 1200;
        for (int i = 0; i < 3000 && rd_phase < 1200; i++) tick(1'b1, (cyc % 7) != 6);
        check("wrap_count", 64'(rd_phase), 64'd1200);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
